// File: rtl/div_pkg.sv
// Shared types and constants for the div_32_bits restoring divider.
// Signed operation in the top is selected with DIV_SIGNED_EN.
package div_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on a {remainder, quotient} pair.
// The remainder is always below the divisor, so the shifted value fits WIDTH+1 bits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_nx,
    output logic [WIDTH-1:0] quo_nx
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           ge;

    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, dvs};
        // A borrow into the top bit means the trial subtraction went negative.
        ge      = ~diff[WIDTH];
        rem_nx  = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_nx  = {quo[WIDTH-2:0], ge};
    end

endmodule

// File: rtl/div_32_bits.sv
// Multi-cycle restoring divider: IDLE -> COMPUTE (WIDTH cycles) -> DONE.
// Define DIV_SIGNED_EN for two's-complement operands; default is unsigned.
module div_32_bits
    import div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             neg;
    logic             ovf;

    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             neg_in;
    logic             ovf_in;
    logic             start;
    logic             b_zero;
    logic             last;

`ifdef DIV_SIGNED_EN
    // Divide magnitudes; the sign is reapplied to the final quotient.
    always_comb begin
        mag_a  = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        mag_b  = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
        neg_in = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        ovf_in = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}})
               && (&data_operandB);
    end
`else
    assign mag_a  = data_operandA;
    assign mag_b  = data_operandB;
    assign neg_in = 1'b0;
    assign ovf_in = 1'b0;
`endif

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem    (rem),
        .quo    (quo),
        .dvs    (dvs),
        .rem_nx (rem_nx),
        .quo_nx (quo_nx)
    );

    assign b_zero = (data_operandB == '0);
    assign last   = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        state_nx       = state;
        busy           = (state == COMPUTE);
        data_resultRDY = (state == DONE);
        start          = ctrl_DIV && (state != COMPUTE);
        unique case (state)
            IDLE: begin
                if (start) state_nx = b_zero ? DONE : COMPUTE;
            end
            COMPUTE: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                if (start) state_nx = b_zero ? DONE : COMPUTE;
                else       state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            rem            <= '0;
            quo            <= '0;
            dvs            <= '0;
            neg            <= 1'b0;
            ovf            <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else begin
            state <= state_nx;
            if (start) begin
                cnt <= '0;
                rem <= '0;
                quo <= mag_a;
                dvs <= mag_b;
                neg <= neg_in;
                ovf <= ovf_in;
                if (b_zero) begin
                    data_result    <= '0;
                    data_exception <= 1'b1;
                end
            end else if (state == COMPUTE) begin
                cnt <= cnt + 1'b1;
                rem <= rem_nx;
                quo <= quo_nx;
                if (last) begin
                    data_result    <= neg ? -quo_nx : quo_nx;
                    data_exception <= ovf;
                end
            end
        end
    end

endmodule

// File: doc/div_32_bits.md
DIV_32_BITS -- requirements
Module: div_32_bits

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port `clock`, input, 1: rising-edge clock.
REQ-004 Port `reset`, input, 1: synchronous, active-high reset.
REQ-005 Port `ctrl_DIV`, input, 1: start request, sampled on each rising edge.
REQ-006 Port `data_operandA`, input, WIDTH: dividend, captured at start.
REQ-007 Port `data_operandB`, input, WIDTH: divisor, captured at start.
REQ-008 Port `data_result`, output, WIDTH: quotient.
REQ-009 Port `data_exception`, output, 1: divide-by-zero or overflow flag, valid while `data_resultRDY` is high.
REQ-010 Port `data_resultRDY`, output, 1: one-cycle completion pulse.
REQ-011 Port `busy`, output, 1: high while a division is in progress.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, COMPUTE and DONE.
REQ-013 A start SHALL be accepted only when `ctrl_DIV`=1 and `busy`=0; acceptance captures both operands and clears the 6-bit step counter.
REQ-014 On an accepted start with divisor 0, the FSM SHALL go directly to DONE with result 0 and `data_exception`=1, so `data_resultRDY` is high in cycle 1.
REQ-015 In COMPUTE, each cycle SHALL perform one restoring step:
  - shift the {remainder, quotient} pair left by one;
  - subtract the divisor from the remainder;
  - if the difference is non-negative, keep it and set the quotient LSB to 1;
  - otherwise restore the remainder and leave the quotient LSB at 0.
REQ-016 COMPUTE SHALL last exactly WIDTH cycles; with a start accepted in cycle 0, `data_resultRDY`=1 in cycle WIDTH+1 (33).
REQ-017 In DONE, `data_resultRDY`=1 for exactly one cycle and `busy`=0; the next state is IDLE, or COMPUTE if a new start is accepted in that cycle (back-to-back operation).
REQ-018 `data_result` and `data_exception` SHALL hold their values from the DONE cycle until the next DONE cycle.
REQ-019 `ctrl_DIV` asserted while `busy`=1 SHALL be ignored, and operand changes while busy SHALL NOT affect the result.
REQ-020 The remainder SHALL be kept internally only and is not an output.

Reset
REQ-021 `reset`=1 at a rising edge SHALL set:
  - state to IDLE;
  - `data_result`, `data_exception`, `data_resultRDY` and `busy` to 0;
  - the counter and the remainder and quotient registers to 0.
REQ-022 Reset during COMPUTE or DONE SHALL abort the operation with no `data_resultRDY` pulse.
REQ-023 Reset SHALL take priority over a simultaneous `ctrl_DIV`.

Configuration
REQ-024 With macro DIV_SIGNED_EN defined, operands SHALL be two's complement:
  - the unit divides magnitudes and negates the quotient when the operand signs differ;
  - the quotient truncates toward zero;
  - -2^(WIDTH-1) / -1 SHALL return 0x80000000 with `data_exception`=1;
  - latency is unchanged.
REQ-025 Without DIV_SIGNED_EN, operands SHALL be unsigned, and the only exception is divide-by-zero.

Structure
REQ-026 Shared package div_pkg SHALL contain:
  - the state enum (IDLE, COMPUTE, DONE);
  - the WIDTH default constant;
  - the counter width constant (6).
REQ-027 One sub-module, div_step, SHALL implement the combinational restoring step (inputs: remainder, quotient, divisor; outputs: next remainder, next quotient).
REQ-028 The FSM, counter and registers SHALL reside in div_32_bits.

Verification
REQ-029 Unsigned 100 / 7, start in cycle 0: `data_resultRDY`=1 in cycle 33, result 0x0000000E, exception 0.
REQ-030 5 / 0: `data_resultRDY`=1 in cycle 1, result 0x00000000, exception 1.
REQ-031 Unsigned 0xFFFFFFFF / 1 -> 0xFFFFFFFF. With DIV_SIGNED_EN:
  - -100 / 7 -> 0xFFFFFFF2;
  - 0x80000000 / 0xFFFFFFFF -> 0x80000000 with exception 1.
REQ-032 Start 100 / 7, then `ctrl_DIV` pulsed with 9 / 3 in cycle 10: the second request is ignored and the result is 0x0000000E in cycle 33.
REQ-033 Start 100 / 7, reset in cycle 20: `busy`=0 in cycle 21, and no `data_resultRDY` pulse occurs through cycle 40.
REQ-034 Start 100 / 7, then start 81 / 9 in the DONE cycle (cycle 33): the second result is 0x00000009 in cycle 66.
